// File: rtl/fb_stream_writer.sv
//-----------------------------------------------------------------------------
// fb_stream_writer
//
// Purpose:
//   Accepts a raster-ordered pixel stream (valid/ready with start-of-frame
//   marker) and turns it into registered frame-buffer write strobes. A frame
//   starts only on an SOF beat; once the last pixel of the frame is written
//   the block stalls the stream (FULL) until the display side signals a frame
//   boundary with frame_tick.
//
// Configuration:
//   FB_DOUBLE_BUFFER_EN  defined   : two banks; frame_tick in FULL hands the
//                                    freshly written bank to the display
//                                    (rd_bank <= wr_bank) and flips wr_bank.
//                        undefined : single bank; wr_bank = rd_bank = 0 and
//                                    frame_tick in FULL only releases the
//                                    stall.
//
// Ports:
//   clk         in  1          rising-edge clock
//   rst         in  1          asynchronous active-high reset
//   s_valid     in  1          pixel beat valid
//   s_data      in  RGB_WIDTH  pixel value (RGB 3-3-2)
//   s_sof       in  1          beat is first pixel of a frame
//   s_ready     out 1          beat accepted when s_valid & s_ready
//   frame_tick  in  1          display frame-boundary strobe
//   wr_en       out 1          registered write strobe
//   wr_addr     out ADDR_W     registered write address (raster order)
//   wr_data     out RGB_WIDTH  registered write data
//   wr_bank     out 1          bank currently being written
//   rd_bank     out 1          bank to display
//   frame_done  out 1          pulses with the final write of a frame
//   err_sof     out 1          pulses with a write caused by a mid-frame SOF
//-----------------------------------------------------------------------------
module fb_stream_writer #(
    parameter int IMG_W     = 320,
    parameter int IMG_H     = 240,
    parameter int ADDR_W    = 17,
    parameter int RGB_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 s_valid,
    input  logic [RGB_WIDTH-1:0] s_data,
    input  logic                 s_sof,
    output logic                 s_ready,
    input  logic                 frame_tick,
    output logic                 wr_en,
    output logic [ADDR_W-1:0]    wr_addr,
    output logic [RGB_WIDTH-1:0] wr_data,
    output logic                 wr_bank,
    output logic                 rd_bank,
    output logic                 frame_done,
    output logic                 err_sof
);

    localparam int X_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int Y_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam logic [X_W-1:0] X_LAST = X_W'(IMG_W - 1);
    localparam logic [Y_W-1:0] Y_LAST = Y_W'(IMG_H - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t state, state_next;

    // Position of the next pixel to be written when no SOF intervenes.
    logic [X_W-1:0]    x_cnt;
    logic [Y_W-1:0]    y_cnt;
    logic [ADDR_W-1:0] addr_cnt;

    logic              accept;
    logic              do_write;
    logic [X_W-1:0]    cur_x;
    logic [Y_W-1:0]    cur_y;
    logic [ADDR_W-1:0] cur_addr;
    logic              x_wrap;
    logic              is_last;

    assign accept   = s_valid & s_ready;
    // In IDLE only an SOF beat starts a frame; other accepted beats are dropped.
    assign do_write = accept & (s_sof | (state == WRITE));

    // An SOF beat always lands on pixel 0, restarting the raster position.
    assign cur_x    = s_sof ? '0 : x_cnt;
    assign cur_y    = s_sof ? '0 : y_cnt;
    assign cur_addr = s_sof ? '0 : addr_cnt;
    assign x_wrap   = (cur_x == X_LAST);
    // Last pixel is detected from x/y, so no IMG_W*IMG_H product is needed.
    assign is_last  = x_wrap && (cur_y == Y_LAST);

    //-------------------------------------------------------------------------
    // FSM: state register
    //-------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples pre-edge values regardless of block ordering.
            state <= state_next;
        end
    end

    //-------------------------------------------------------------------------
    // FSM: next-state logic
    //-------------------------------------------------------------------------
    always_comb begin
        // NOTE: default first so every path assigns state_next (no latch).
        state_next = state;
        unique case (state)
            IDLE:    if (do_write) state_next = is_last ? FULL : WRITE;
            WRITE:   if (do_write && is_last) state_next = FULL;
            FULL:    if (frame_tick) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    //-------------------------------------------------------------------------
    // FSM: outputs (state only, never from s_valid)
    //-------------------------------------------------------------------------
    always_comb begin
        s_ready = (state != FULL);
    end

    //-------------------------------------------------------------------------
    // Raster counters and registered write port
    //-------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_cnt      <= '0;
            y_cnt      <= '0;
            addr_cnt   <= '0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            frame_done <= 1'b0;
            err_sof    <= 1'b0;
        end else begin
            wr_en      <= do_write;
            frame_done <= do_write && is_last;
            err_sof    <= do_write && s_sof && (state == WRITE);
            if (do_write) begin
                wr_addr  <= cur_addr;
                wr_data  <= s_data;
                addr_cnt <= cur_addr + 1'b1;
                if (x_wrap) begin
                    x_cnt <= '0;
                    y_cnt <= is_last ? '0 : cur_y + 1'b1;
                end else begin
                    x_cnt <= cur_x + 1'b1;
                    y_cnt <= cur_y;
                end
            end
        end
    end

    //-------------------------------------------------------------------------
    // Bank selection
    //-------------------------------------------------------------------------
`ifdef FB_DOUBLE_BUFFER_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_bank <= 1'b0;
            rd_bank <= 1'b0;
        end else if ((state == FULL) && frame_tick) begin
            rd_bank <= wr_bank;
            wr_bank <= ~wr_bank;
        end
    end
`else
    assign wr_bank = 1'b0;
    assign rd_bank = 1'b0;
`endif

endmodule
